// File: rtl/riscv_pkg.sv
// Shared types and constants for the common data bus arbiter.
// Module parameters mirror the defaults held here.
package riscv_pkg;

    localparam int NFU       = 3;
    localparam int CDB_WIDTH = 31;
    localparam int CDB_ROB   = 2;

    typedef struct packed {
        logic [CDB_WIDTH:0] result;
        logic [CDB_ROB:0]   rob;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Two-entry completion buffer for one functional unit.
// Clear empties the buffer and wins over push and pop.
module cdb_fifo
    import riscv_pkg::*;
#(
    parameter int DW = $bits(cdb_entry_t)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [1:0]    count,
    output logic [DW-1:0] head
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != 2'd2) && !clear;
    assign do_pop  = pop && (count != 2'd0) && !clear;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that funnels functional-unit results
// onto a registered common data bus broadcast.
module cdb_arbiter
    import riscv_pkg::*;
#(
    parameter int WIDTH = riscv_pkg::CDB_WIDTH,
    parameter int ROB   = riscv_pkg::CDB_ROB,
    parameter int NFU   = riscv_pkg::NFU,
    localparam int SW   = (NFU > 1) ? $clog2(NFU) : 1
) (
    input  logic                      clk,
    input  logic                      globalReset,
    input  logic [NFU-1:0]            fuValid,
    input  logic [NFU-1:0][WIDTH:0]   fuResult,
    input  logic [NFU-1:0][ROB:0]     fuRob,
    output logic [NFU-1:0]            fuReady,
    input  logic                      clear,
    input  logic                      cdbStall,
    output logic                      cdbValid,
    output logic [WIDTH:0]            cdbResult,
    output logic [ROB:0]              cdbRob,
    output logic [SW-1:0]             cdbSrc
);

    localparam int DW = WIDTH + ROB + 2;

    typedef struct packed {
        logic [WIDTH:0] result;
        logic [ROB:0]   rob;
    } entry_t;

    logic [NFU-1:0][1:0] count;
    entry_t [NFU-1:0]    head;
    logic [NFU-1:0]      busy;
    logic [NFU-1:0]      push;
    logic [NFU-1:0]      pop;
    logic [SW-1:0]       rr_ptr;
    logic [SW-1:0]       win;
    logic [SW-1:0]       nxt;
    logic                found;
    logic                advance;
    logic                grant;

    // Scan downward so the lowest offset from ptr is the last hit.
    function automatic logic [SW:0] rr_pick(
        input logic [NFU-1:0] req,
        input logic [SW-1:0]  ptr
    );
        logic [SW:0]   r;
        logic [SW-1:0] j;
        r = '0;
        for (int k = NFU - 1; k >= 0; k--) begin
            j = SW'((int'(ptr) + k) % NFU);
            if (req[j]) r = {1'b1, j};
        end
        return r;
    endfunction

    always_comb begin
        busy    = '0;
        fuReady = '0;
        for (int i = 0; i < NFU; i++) begin
            busy[i]    = count[i] != 2'd0;
            fuReady[i] = count[i] != 2'd2;
        end
    end

    assign push           = fuValid & fuReady;
    assign {found, win}   = rr_pick(busy, rr_ptr);
    assign advance        = !cdbValid || !cdbStall;
    assign grant          = advance && found && !clear;
    assign nxt            = (win == SW'(NFU - 1)) ? '0 : win + 1'b1;

    for (genvar i = 0; i < NFU; i++) begin : g_fifo
        assign pop[i] = grant && (win == SW'(i));

        cdb_fifo #(
            .DW (DW)
        ) u_fifo (
            .clk   (clk),
            .rst_n (globalReset),
            .clear (clear),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   ({fuResult[i], fuRob[i]}),
            .count (count[i]),
            .head  (head[i])
        );
    end

    always_ff @(posedge clk or negedge globalReset) begin
        if (!globalReset) begin
            cdbValid  <= 1'b0;
            cdbResult <= '0;
            cdbRob    <= '0;
            cdbSrc    <= '0;
            rr_ptr    <= '0;
        end else if (clear) begin
            cdbValid <= 1'b0;
            rr_ptr   <= '0;
        end else if (advance) begin
            if (found) begin
                cdbValid  <= 1'b1;
                cdbResult <= head[win].result;
                cdbRob    <= head[win].rob;
                cdbSrc    <= win;
                rr_ptr    <= nxt;
            end else begin
                cdbValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: single push, contention,
// backpressure, flush, fairness and asynchronous reset.
module tb_cdb_arbiter;

    localparam int WIDTH = 31;
    localparam int ROB   = 2;
    localparam int NFU   = 3;
    localparam int SW    = 2;

    logic                    clk = 1'b0;
    logic                    globalReset;
    logic [NFU-1:0]          fuValid;
    logic [NFU-1:0][WIDTH:0] fuResult;
    logic [NFU-1:0][ROB:0]   fuRob;
    logic [NFU-1:0]          fuReady;
    logic                    clear;
    logic                    cdbStall;
    logic                    cdbValid;
    logic [WIDTH:0]          cdbResult;
    logic [ROB:0]            cdbRob;
    logic [SW-1:0]           cdbSrc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .WIDTH (WIDTH),
        .ROB   (ROB),
        .NFU   (NFU)
    ) dut (
        .clk         (clk),
        .globalReset (globalReset),
        .fuValid     (fuValid),
        .fuResult    (fuResult),
        .fuRob       (fuRob),
        .fuReady     (fuReady),
        .clear       (clear),
        .cdbStall    (cdbStall),
        .cdbValid    (cdbValid),
        .cdbResult   (cdbResult),
        .cdbRob      (cdbRob),
        .cdbSrc      (cdbSrc)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bcast(input string tag, input logic [63:0] res,
                         input logic [63:0] rob, input logic [63:0] src);
        chk({tag, ".valid"},  64'(cdbValid),  64'd1);
        chk({tag, ".result"}, 64'(cdbResult), res);
        chk({tag, ".rob"},    64'(cdbRob),    rob);
        chk({tag, ".src"},    64'(cdbSrc),    src);
    endtask

    task automatic idle(input string tag);
        chk({tag, ".valid"}, 64'(cdbValid), 64'd0);
    endtask

    initial begin
        globalReset = 1'b0;
        fuValid     = '0;
        fuResult    = '0;
        fuRob       = '0;
        clear       = 1'b0;
        cdbStall    = 1'b0;

        #3;
        idle("rst");
        chk("rst.result", 64'(cdbResult), 64'd0);
        chk("rst.rob",    64'(cdbRob),    64'd0);
        chk("rst.src",    64'(cdbSrc),    64'd0);
        chk("rst.ready",  64'(fuReady),   64'h7);
        step();
        step();
        globalReset = 1'b1;
        step();
        idle("rst_rel");

        // single push
        fuValid     = 3'b001;
        fuResult[0] = 32'h0000_00AA;
        fuRob[0]    = 3'd3;
        step();
        fuValid = '0;
        idle("single.e1");
        step();
        bcast("single.e2", 64'hAA, 64'd3, 64'd0);
        step();
        idle("single.e3");

        clear = 1'b1;
        step();
        clear = 1'b0;
        idle("clr0");
        chk("clr0.rr", 64'(dut.rr_ptr), 64'd0);

        // contention
        fuValid  = 3'b111;
        fuResult = {32'h30, 32'h20, 32'h10};
        fuRob    = {3'd3, 3'd2, 3'd1};
        step();
        fuValid = '0;
        step();
        bcast("cont.0", 64'h10, 64'd1, 64'd0);
        step();
        bcast("cont.1", 64'h20, 64'd2, 64'd1);
        step();
        bcast("cont.2", 64'h30, 64'd3, 64'd2);
        step();
        idle("cont.end");
        chk("cont.rr", 64'(dut.rr_ptr), 64'd0);

        // backpressure
        cdbStall    = 1'b1;
        fuValid     = 3'b010;
        fuResult[1] = 32'h100;
        fuRob[1]    = 3'd4;
        step();
        idle("bp.e1");
        fuResult[1] = 32'h101;
        fuRob[1]    = 3'd5;
        step();
        bcast("bp.e2", 64'h100, 64'd4, 64'd1);
        fuResult[1] = 32'h102;
        fuRob[1]    = 3'd6;
        step();
        chk("bp.e3.ready", 64'(fuReady), 64'h5);
        bcast("bp.e3", 64'h100, 64'd4, 64'd1);
        fuResult[1] = 32'h103;
        fuRob[1]    = 3'd7;
        step();
        bcast("bp.e4", 64'h100, 64'd4, 64'd1);
        step();
        bcast("bp.e5", 64'h100, 64'd4, 64'd1);
        chk("bp.e5.ready", 64'(fuReady), 64'h5);
        cdbStall = 1'b0;
        step();
        bcast("bp.e6", 64'h101, 64'd5, 64'd1);
        step();
        bcast("bp.e7", 64'h102, 64'd6, 64'd1);
        fuValid = '0;
        step();
        bcast("bp.e8", 64'h103, 64'd7, 64'd1);
        step();
        idle("bp.e9");

        // flush
        cdbStall    = 1'b1;
        fuValid     = 3'b100;
        fuResult[2] = 32'hC0;
        fuRob[2]    = 3'd0;
        step();
        idle("fl.f1");
        fuValid     = 3'b011;
        fuResult[0] = 32'hA0;
        fuRob[0]    = 3'd1;
        fuResult[1] = 32'hB0;
        fuRob[1]    = 3'd2;
        step();
        bcast("fl.f2", 64'hC0, 64'd0, 64'd2);
        fuResult[0] = 32'hA1;
        fuResult[1] = 32'hB1;
        step();
        bcast("fl.f3", 64'hC0, 64'd0, 64'd2);
        chk("fl.f3.ready", 64'(fuReady), 64'h4);
        fuValid = '0;
        clear   = 1'b1;
        step();
        clear    = 1'b0;
        cdbStall = 1'b0;
        idle("fl.f4");
        chk("fl.f4.ready", 64'(fuReady), 64'h7);
        for (int k = 0; k < 3; k++) begin
            step();
            idle("fl.drain");
        end

        // fairness
        fuValid     = 3'b101;
        fuResult[0] = 32'h50;
        fuRob[0]    = 3'd1;
        fuResult[2] = 32'h70;
        fuRob[2]    = 3'd5;
        step();
        idle("fair.g1");
        fuValid     = 3'b001;
        fuResult[0] = 32'h51;
        step();
        bcast("fair.g2", 64'h50, 64'd1, 64'd0);
        fuResult[0] = 32'h52;
        step();
        bcast("fair.g3", 64'h70, 64'd5, 64'd2);
        fuValid = '0;
        step();
        bcast("fair.g4", 64'h51, 64'd1, 64'd0);
        step();
        bcast("fair.g5", 64'h52, 64'd1, 64'd0);
        step();
        idle("fair.end");

        // async reset with full buffers
        cdbStall = 1'b1;
        fuValid  = 3'b111;
        fuResult = {32'hE2, 32'hE1, 32'hE0};
        fuRob    = {3'd3, 3'd2, 3'd1};
        step();
        idle("ar.h1");
        step();
        bcast("ar.h2", 64'hE1, 64'd2, 64'd1);
        step();
        chk("ar.h3.ready", 64'(fuReady), 64'h0);
        #2;
        globalReset = 1'b0;
        #1;
        idle("ar.async");
        chk("ar.result", 64'(cdbResult), 64'd0);
        chk("ar.rob",    64'(cdbRob),    64'd0);
        chk("ar.src",    64'(cdbSrc),    64'd0);
        chk("ar.ready",  64'(fuReady),   64'h7);
        fuValid  = '0;
        cdbStall = 1'b0;
        step();
        globalReset = 1'b1;
        step();
        idle("ar.rel1");
        step();
        idle("ar.rel2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
